// File: rtl/loop_ctrl_pkg.sv
// Shared constants for the iteration controller: FSM state encoding and default iteration count.
package loop_ctrl_pkg;

    localparam int unsigned M_ITER = 97;

    localparam int unsigned ST_W = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage : loop_ctrl_pkg

// File: rtl/loop_index_counter.sv
// Iteration index counter: synchronous clear, saturating increment, registered at-last flag.
module loop_index_counter
    import loop_ctrl_pkg::*;
#(
    parameter int unsigned COUNT = M_ITER,
    parameter int unsigned IW    = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [IW-1:0] idx_o,
    output logic          at_last_o
);

    localparam logic [IW-1:0] LAST = IW'(COUNT - 1);

    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic          at_last_q;

    // Next index: clear wins; increment stops at the last index so a run never wraps.
    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i && !at_last_q) begin
            idx_d = idx_q + IW'(1);
        end
    end

    // Index and at-last flag registers; the flag tracks idx_d so it is valid alongside idx_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q     <= '0;
            at_last_q <= (LAST == '0);
        end else begin
            idx_q     <= idx_d;
            at_last_q <= (idx_d == LAST);
        end
    end

    assign idx_o     = idx_q;
    assign at_last_o = at_last_q;

endmodule : loop_index_counter

// File: rtl/loop_ctrl.sv
// Iteration controller: on a start pulse, issues COUNT go pulses to the datapath,
// each gated by the datapath's completion pulse, then holds a done level.
module loop_ctrl
    import loop_ctrl_pkg::*;
#(
    parameter int unsigned COUNT = M_ITER,
    parameter int unsigned IW    = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          op_done,
    output logic          op_go,
    output logic [IW-1:0] idx,
    output logic          busy,
    output logic          done
);

    generate
        if (COUNT < 1 || (64'(1) << IW) < 64'(COUNT)) begin : g_bad_params
            $error("loop_ctrl: COUNT must be >= 1 and fit in IW bits");
        end
    endgenerate

    logic [ST_W-1:0] state_q;
    logic [ST_W-1:0] state_d;
    logic            op_go_q;
    logic            op_go_d;
    logic            busy_q;
    logic            busy_d;
    logic            done_q;
    logic            done_d;
    logic            idx_clr;
    logic            idx_inc;
    logic            at_last;

    loop_index_counter #(
        .COUNT (COUNT),
        .IW    (IW)
    ) u_idx (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (idx_clr),
        .inc_i     (idx_inc),
        .idx_o     (idx),
        .at_last_o (at_last)
    );

    // Next-state and counter control; outputs are decoded from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        idx_clr = 1'b0;
        idx_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    idx_clr = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (op_done) begin
                    if (at_last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        idx_inc = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    idx_clr = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        op_go_d = (state_d == ST_ISSUE);
        busy_d  = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
        done_d  = (state_d == ST_DONE);
    end

    // State and output registers; reset abandons any run immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_go_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_go_q <= op_go_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign op_go = op_go_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule : loop_ctrl

// File: doc/loop_ctrl.md
Name: loop_ctrl

Overview:
- Iteration controller sitting directly downstream of the start-level-to-pulse converter.
- Consumes the one-cycle start pulse and runs a fixed number of iterations (Miller-loop style).
- Each iteration issues one go pulse to the arithmetic datapath and waits for that datapath's completion pulse.
- After the last iteration it holds a done level, which the next pulse converter downstream turns back into a pulse.

Parameters:
- COUNT, 97, number of iterations per run; must be ≥1.
- IW, 7, width of the iteration index; must satisfy 2^IW ≥ COUNT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle start pulse from the upstream edge converter.
- op_done  input  1  one-cycle pulse from the datapath: current iteration finished.
- op_go  output  1  one-cycle pulse to the datapath: begin iteration idx.
- idx  output  IW  current iteration index, 0..COUNT-1.
- busy  output  1  high while a run is in progress.
- done  output  1  level; high from run completion until the next start or reset.

Behaviour:
- All outputs are registered; no combinational path from any input to any output.
- Reset value: state=IDLE, op_go=0, idx=0, busy=0, done=0.
- Reset is asynchronous and takes effect mid-run: the run is abandoned and no further op_go is issued.
- States:
  - IDLE: busy=0, done=0. start=1 -> ISSUE with idx=0.
  - ISSUE: lasts exactly one cycle, op_go=1, busy=1. Always -> WAIT. op_done in this cycle is ignored.
  - WAIT: op_go=0, busy=1. op_done=1 and idx==COUNT-1 -> DONE. op_done=1 and idx<COUNT-1 -> idx+1, then ISSUE. op_done=0 -> stay.
  - DONE: done=1, busy=0, idx holds COUNT-1. start=1 -> ISSUE, idx=0, done cleared on the same edge.
- Latency:
  - start sampled at edge t -> op_go=1 and busy=1 in cycle t+1.
  - op_done sampled at edge t -> next op_go in cycle t+1, with idx already incremented.
  - Final op_done at edge t -> done=1 in cycle t+1.
- start while busy (ISSUE or WAIT) is ignored: no restart, idx unchanged.
- op_done in IDLE or DONE is ignored.
- start and op_done in the same cycle while in WAIT: op_done is processed, start is ignored.
- idx never exceeds COUNT-1; no wrap-around within a run. idx is compared as unsigned IW-bit against COUNT-1.
- COUNT=1: a single ISSUE/WAIT pair, then DONE.
- op_go is high exactly COUNT times per run, never in two consecutive cycles.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE (2 bits);
  - default iteration count constant M_ITER=97.
- One natural sub-module: loop_index_counter. It provides a clear/increment IW-bit counter with an at_last flag (idx==COUNT-1), asynchronous reset, and is instantiated once.
- The FSM remains in loop_ctrl.

Test Plan:
- Reset then idle (COUNT=3): hold reset 3 cycles, release, no stimulus for 10 cycles -> op_go=0, busy=0, done=0, idx=0 throughout.
- Full run (COUNT=3): start pulse at cycle 5 and op_done 4 cycles after each op_go -> op_go at cycles 6, 11, 16 with idx=0, 1, 2; done=1 from cycle 21 and held; busy=1 over cycles 6..20.
- start while busy (COUNT=3): second start during the WAIT of idx=1 -> no extra op_go, idx sequence unchanged, exactly 3 op_go pulses.
- Back-to-back runs (COUNT=3): start during DONE -> done drops and op_go rises next cycle with idx=0; second run completes identically.
- Spurious op_done: op_done in IDLE, in the ISSUE cycle, and in DONE -> no state change, idx unchanged, no op_go.
- Async reset mid-run (default COUNT=97): assert reset between clock edges while idx=40 in WAIT -> outputs go to 0 immediately without a clock edge; after release, later op_done pulses are ignored until a new start.
